// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings, FSM states and alignment check for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] DMEM_BYTE = 2'b00;
    localparam logic [1:0] DMEM_HALF = 2'b01;
    localparam logic [1:0] DMEM_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == DMEM_HALF && off[0]) || (size == DMEM_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables and lane-replicated store data; right-justified, size-masked load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        be        = size == DMEM_BYTE ? 4'b0001 << off :
                    size == DMEM_HALF ? 4'b0011 << off : 4'b1111;
        wdata_rep = size == DMEM_BYTE ? {4{wdata[7:0]}} :
                    size == DMEM_HALF ? {2{wdata[15:0]}} : wdata;
        shifted   = raw >> {off, 3'b000};
        rdata     = size == DMEM_BYTE ? {24'h0, shifted[7:0]} :
                    size == DMEM_HALF ? {16'h0, shifted[15:0]} : shifted;
    end

endmodule

// File: rtl/dmem_resp_unit.sv
// dmem_resp_unit: data-memory responder with programmable wait states, stall generation and error reporting.
module dmem_resp_unit
    import dmem_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LATENCY     = 2
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] dmem_addr_i,
    input  logic [XLEN-1:0] dmem_wdata_i,
    input  logic [1:0]      dmem_size_i,
    input  logic            dmem_req_i,
    input  logic            dmem_wen_i,
    input  logic            dmem_flush_i,
    output logic            dmem_stall_o,
    output logic [XLEN-1:0] dmem_rdata_o,
    output logic            dmem_rvalid_o,
    output logic            dmem_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e     state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [1:0]      size_q;
    logic            wen_q;

    logic            in_wait, accept, access, a_err, a_wen, we;
    logic [XLEN-1:0] a_addr, a_wdata, widx;
    logic [1:0]      a_size;
    logic [3:0]      be;
    logic [31:0]     wdata_rep, rdata_al;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // With LATENCY=0 the access uses the live request; otherwise the copy latched at acceptance.
    always_comb begin
        in_wait      = state == WAIT;
        accept       = !in_wait && dmem_req_i && !dmem_flush_i;
        access       = !dmem_flush_i && (in_wait ? cnt == 4'd0 : accept && LATENCY == 0);
        a_addr       = in_wait ? addr_q : dmem_addr_i;
        a_wdata      = in_wait ? wdata_q : dmem_wdata_i;
        a_size       = in_wait ? size_q : dmem_size_i;
        a_wen        = in_wait ? wen_q : dmem_wen_i;
        widx         = (a_addr - XLEN'(BASE_ADDR)) >> 2;
        a_err        = a_size == 2'b11 || dmem_misaligned(a_size, a_addr[1:0]) ||
                       widx >= XLEN'(DEPTH_WORDS);
        we           = access && a_wen && !a_err && !reset_i;
        dmem_stall_o = !dmem_flush_i && ((accept && LATENCY != 0) || (in_wait && cnt != 4'd0));
    end

    dmem_lane_align u_align (
        .size      (a_size),
        .off       (a_addr[1:0]),
        .wdata     (a_wdata),
        .raw       (mem[widx[AW-1:0]]),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata     (rdata_al)
    );

    always_ff @(posedge clock_i) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx[AW-1:0]][8*i +: 8] <= wdata_rep[8*i +: 8];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= 2'b00;
            wen_q         <= 1'b0;
            dmem_rvalid_o <= 1'b0;
            dmem_err_o    <= 1'b0;
            dmem_rdata_o  <= '0;
        end else begin
            dmem_rvalid_o <= access && !a_err && !a_wen;
            dmem_err_o    <= access && a_err;
            dmem_rdata_o  <= (access && !a_err && !a_wen) ? rdata_al : '0;
            if (dmem_flush_i) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else if (in_wait) begin
                if (cnt == 4'd0) state <= RESP;
                else cnt <= cnt - 4'd1;
            end else if (accept) begin
                addr_q  <= dmem_addr_i;
                wdata_q <= dmem_wdata_i;
                size_q  <= dmem_size_i;
                wen_q   <= dmem_wen_i;
                state   <= LATENCY == 0 ? RESP : WAIT;
                cnt     <= LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp_unit.sv
// tb_dmem_resp_unit: directed vector table across LATENCY 0/2/3 instances plus flush, back-to-back and reset sequences.
module tb_dmem_resp_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  size = 2'b00;
    logic        wen = 1'b0, flush = 1'b0;
    logic        req [3];
    logic        stall [3], rvalid [3], err [3];
    logic [31:0] rdata [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_resp_unit #(.LATENCY(0)) u0 (
        .clock_i(clk), .reset_i(rst), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_size_i(size), .dmem_req_i(req[0]), .dmem_wen_i(wen), .dmem_flush_i(flush),
        .dmem_stall_o(stall[0]), .dmem_rdata_o(rdata[0]), .dmem_rvalid_o(rvalid[0]), .dmem_err_o(err[0]));

    dmem_resp_unit #(.LATENCY(2)) u1 (
        .clock_i(clk), .reset_i(rst), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_size_i(size), .dmem_req_i(req[1]), .dmem_wen_i(wen), .dmem_flush_i(flush),
        .dmem_stall_o(stall[1]), .dmem_rdata_o(rdata[1]), .dmem_rvalid_o(rvalid[1]), .dmem_err_o(err[1]));

    dmem_resp_unit #(.LATENCY(3)) u2 (
        .clock_i(clk), .reset_i(rst), .dmem_addr_i(addr), .dmem_wdata_i(wdata),
        .dmem_size_i(size), .dmem_req_i(req[2]), .dmem_wen_i(wen), .dmem_flush_i(flush),
        .dmem_stall_o(stall[2]), .dmem_rdata_o(rdata[2]), .dmem_rvalid_o(rvalid[2]), .dmem_err_o(err[2]));

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        wen;
        logic        exp_err;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        int          exp_stall;
    } vec_t;

    localparam int NV = 22;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic start(input int d, input logic [31:0] a, input logic [31:0] w,
                         input logic [1:0] s, input logic we);
        addr = a; wdata = w; size = s; wen = we; req[d] = 1'b1;
    endtask

    // Holds the request while stalled, then samples the RESP cycle and releases req.
    task automatic complete(input int d, output int n, output logic e, output logic rv,
                            output logic [31:0] rd);
        n = 0;
        forever begin
            #1;
            if (!stall[d]) break;
            n++;
            if (n > 40) begin
                failures++; checks++;
                $display("FAIL stall_timeout: dut %0d stalled %0d cycles", d, n);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        e = err[d]; rv = rvalid[d]; rd = rdata[d];
        req[d] = 1'b0;
    endtask

    int          n;
    logic        e, rv;
    logic [31:0] rd;
    time         t0;
    logic        seen;

    initial begin
        vec[0]  = '{1, 32'h10,       32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0,        2};
        vec[1]  = '{1, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2};
        vec[2]  = '{0, 32'h10,       32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0,        0};
        vec[3]  = '{0, 32'h13,       32'h000000AA, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0,        0};
        vec[4]  = '{0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 32'hAAADBEEF, 0};
        vec[5]  = '{0, 32'h11,       32'h0,        2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        0};
        vec[6]  = '{0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 32'hAAADBEEF, 0};
        vec[7]  = '{0, 32'h12,       32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 32'h000000AD, 0};
        vec[8]  = '{0, 32'h12,       32'h0,        2'b01, 1'b0, 1'b0, 1'b1, 32'h0000AAAD, 0};
        vec[9]  = '{0, 32'h12,       32'hFFFF1234, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0,        0};
        vec[10] = '{0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 32'h1234BEEF, 0};
        vec[11] = '{0, 32'h1000,     32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        0};
        vec[12] = '{0, 32'hFFFFFFFC, 32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        0};
        vec[13] = '{0, 32'h10,       32'h0,        2'b11, 1'b0, 1'b1, 1'b0, 32'h0,        0};
        vec[14] = '{0, 32'h12,       32'hCAFEF00D, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0,        0};
        vec[15] = '{0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 32'h1234BEEF, 0};
        vec[16] = '{0, 32'hFFC,      32'hA5A5A5A5, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0,        0};
        vec[17] = '{0, 32'hFFD,      32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 32'h000000A5, 0};
        vec[18] = '{2, 32'h20,       32'h11223344, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0,        3};
        vec[19] = '{2, 32'h20,       32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 32'h11223344, 3};
        vec[20] = '{1, 32'h13,       32'h0,        2'b00, 1'b0, 1'b0, 1'b1, 32'h000000DE, 2};
        vec[21] = '{1, 32'h1000,     32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        2};

        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_stall%0d", i), {31'h0, stall[i]}, 32'h0);
            chk($sformatf("reset_rvalid%0d", i), {31'h0, rvalid[i]}, 32'h0);
            chk($sformatf("reset_err%0d", i), {31'h0, err[i]}, 32'h0);
            chk($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            start(vec[i].d, vec[i].addr, vec[i].wdata, vec[i].size, vec[i].wen);
            complete(vec[i].d, n, e, rv, rd);
            chk($sformatf("v%0d_stall_cycles", i), 32'(n), 32'(vec[i].exp_stall));
            chk($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, vec[i].exp_err});
            chk($sformatf("v%0d_rvalid", i), {31'h0, rv}, {31'h0, vec[i].exp_rv});
            chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
            @(negedge clk);
        end

        // Flush during WAIT on the LATENCY=3 instance drops the store.
        start(2, 32'h20, 32'h55667788, 2'b10, 1'b1);
        #1 chk("flush_stall_T", {31'h0, stall[2]}, 32'h1);
        @(negedge clk);
        flush = 1'b1; req[2] = 1'b0;
        #1 chk("flush_stall_drop", {31'h0, stall[2]}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rvalid[2] | err[2] | stall[2];
        end
        chk("flush_no_resp", {31'h0, seen}, 32'h0);
        start(2, 32'h20, 32'h0, 2'b10, 1'b0);
        complete(2, n, e, rv, rd);
        chk("flush_old_data", rd, 32'h11223344);
        @(negedge clk);

        // Back-to-back on LATENCY=2: second request issued in the RESP cycle.
        start(1, 32'h10, 32'h0, 2'b10, 1'b0);
        complete(1, n, e, rv, rd);
        chk("b2b_first_rdata", rd, 32'hDEADBEEF);
        t0 = $time;
        start(1, 32'h11, 32'h0, 2'b00, 1'b0);
        #1 chk("b2b_stall_reassert", {31'h0, stall[1]}, 32'h1);
        complete(1, n, e, rv, rd);
        chk("b2b_latency", 32'(($time - t0) / 10), 32'd3);
        chk("b2b_rvalid", {31'h0, rv}, 32'h1);
        chk("b2b_rdata", rd, 32'h000000BE);
        @(negedge clk);

        // Reset in the middle of a WAIT leaves the array untouched.
        start(2, 32'h20, 32'h99999999, 2'b10, 1'b1);
        @(negedge clk);
        rst = 1'b1; req[2] = 1'b0;
        @(negedge clk);
        chk("rst_mid_wait_stall", {31'h0, stall[2]}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        start(2, 32'h20, 32'h0, 2'b10, 1'b0);
        complete(2, n, e, rv, rd);
        chk("rst_mid_wait_data", rd, 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
